rx_prbs_checker: RTL
====================

// Module: rx_prbs_checker
// PURPOSE
//  Receive-side counterpart of the PRBS modulator chain: takes the oversampled filtered sample stream,
//  decimates to one sample per symbol at a programmable phase, slices to bits, self-syncs a local PRBS9
//  and counts bit errors. Sits after the channel/FIR output; o_lock and the counters feed the LED/debug logic.
// PARAMETERS
//  NB_DATA   8   sample width, signed two's complement
//  OS        8   samples per symbol (power of 2); matches tx valid period (2**NB_COUNT)
//  NB_PHASE  3   log2(OS), width of phase select / sample counter
//  NB_ERR    16  error counter width
//  NB_BITS   32  checked-bit counter width
//  WIN_LEN   64  lock-monitor window in bits (power of 2)
//  ERR_THR   8   window errors that force loss of lock
// PORTS
//  clock        in   1         system clock
//  i_reset      in   1         synchronous reset, active-low
//  i_enable     in   1         1 = run; 0 = freeze all state, outputs hold
//  i_valid      in   1         i_sample valid this cycle (sample rate)
//  i_sample     in   NB_DATA   signed filtered sample
//  i_phase      in   NB_PHASE  which sample of each OS group is the symbol decision point
//  i_clear      in   1         synchronous clear of o_err_count/o_bit_count
//  o_bit        out  1         sliced bit
//  o_bit_valid  out  1         one-cycle strobe qualifying o_bit
//  o_lock       out  1         1 while in CHECK state
//  o_err_count  out  NB_ERR    errors since clear (CHECK state only)
//  o_bit_count  out  NB_BITS   bits compared since clear (CHECK state only)
// BEHAVIOUR
//  Reset (i_reset==0 at posedge): all outputs 0, sample counter 0, FSM SEARCH, fill count 0, LFSR 0.
//  Accept = i_valid & i_enable. Sample counter +1 on accept, wraps OS-1 -> 0.
//  Decision sample: accept while sample counter == i_phase. Changing i_phase mid-run takes effect next accept.
//  Slicer: bit = i_sample[NB_DATA-1] (BPSK map 0->positive, 1->negative; zero sample -> 0).
//  o_bit/o_bit_valid registered: strobe exactly 1 cycle after decision sample; otherwise o_bit_valid=0.
//  PRBS9 x^9+x^5+1: predicted = lfsr[8]^lfsr[4]; lfsr <= {lfsr[7:0], bit}.
//  FSM SEARCH: each decided bit shifts into lfsr, fill +1. At fill==9: lfsr nonzero -> CHECK;
//   lfsr all-zero -> fill=0, stay SEARCH (no lock on all-zero).
//  FSM CHECK: each decided bit: err = bit ^ predicted; lfsr shifts in predicted (not rx bit).
//   bit_count+1, err_count+err, window errors+err; window counter +1 wraps at WIN_LEN, clearing window errors.
//   Window errors reaching ERR_THR -> SEARCH next cycle, fill=0, window state cleared; counters keep values.
//  o_lock = (state==CHECK), registered; rises 1 cycle after the 9th fill bit.
//  i_clear: counters -> 0 next cycle; clear wins over a simultaneous increment; FSM unaffected.
//  i_enable=0: no state changes, o_bit_valid forced 0; i_clear still honoured.
//  Counter overflow: see CONFIGURATION.
// CONFIGURATION
//  Macro RX_BER_SAT_EN defined: o_err_count/o_bit_count saturate at all-ones and hold.
//  Not defined: both counters wrap modulo 2**N. No other behaviour differs.
// STRUCTURE
//  Shared package rx_pkg: FSM state encoding (SEARCH=0, CHECK=1), PRBS9 length/tap constants,
//   BPSK map constant; shared with tx PRBS so seed/taps cannot diverge.
//  Sub-module rx_prbs_sync: LFSR + fill counter + FSM + window monitor; top holds decimator,
//   slicer, output regs, BER counters.
// TESTING
//  1 TX PRBS9 bit stream mapped to +/-64, OS=8, i_phase=3 -> o_lock within 10 symbols, o_err_count=0
//    after 1000 bits, o_bit_count=1000 minus the 9 fill bits.
//  2 Locked, flip 1 bit in 100 -> o_err_count=1 per flip, o_lock stays 1 (<8 per 64-bit window).
//  3 Locked, feed 16 consecutive inverted bits -> o_lock drops within 1 cycle of 8th window error,
//    relocks after 9 clean bits; counters retain pre-loss values.
//  4 All-zero sample stream (positive samples) -> o_lock never asserts, fill restarts every 9 bits.
//  5 i_clear on same cycle as an error bit -> both counters read 0 next cycle; i_reset=0 mid-CHECK -> all outputs 0.
//  6 Preload err_count to max-1, inject 2 errors -> all-ones with RX_BER_SAT_EN, 0 without.
//    i_enable=0 for 20 cycles mid-stream -> no strobes, state unchanged.

Source files
------------

// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared rx/tx PRBS9 constants, sync FSM encoding and BPSK map
package rx_pkg;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_CHECK  = 1'b1
    } sync_state_t;

    // x^9 + x^5 + 1: taps are the register stages holding s[n-9] and s[n-5]
    localparam int PRBS_LEN    = 9;
    localparam int PRBS_TAP_HI = 8;
    localparam int PRBS_TAP_LO = 4;

    // bit value carried by a negative sample; zero and positive samples slice to the other value
    localparam logic BPSK_NEG_BIT = 1'b1;

    function automatic logic prbs9_predict(input logic [PRBS_LEN-1:0] state);
        return state[PRBS_TAP_HI] ^ state[PRBS_TAP_LO];
    endfunction

endpackage

// File: rtl/rx_prbs_sync.sv
// rtl/rx_prbs_sync.sv - self-synchronising PRBS9 tracker with windowed loss-of-lock monitor
module rx_prbs_sync
    import rx_pkg::*;
#(
    parameter int WIN_LEN = 64,
    parameter int ERR_THR = 8
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_bit_valid,
    input  logic i_bit,
    output logic o_lock,
    output logic o_check,
    output logic o_err
);

    localparam int NB_WIN  = $clog2(WIN_LEN);
    localparam int NB_WERR = $clog2(ERR_THR + 1);
    localparam int NB_FILL = $clog2(PRBS_LEN + 1);

    sync_state_t          r_state, w_next_state;
    logic [PRBS_LEN-1:0]  r_lfsr, w_next_lfsr;
    logic [NB_FILL-1:0]   r_fill, w_next_fill;
    logic [NB_WIN-1:0]    r_win_cnt, w_next_win_cnt;
    logic [NB_WERR-1:0]   r_win_err, w_next_win_err;

    logic                 w_pred;
    logic                 w_err;
    logic [PRBS_LEN-1:0]  w_shift_rx;
    logic [NB_WERR-1:0]   w_werr_sum;

    assign w_pred     = prbs9_predict(r_lfsr);
    assign w_err      = i_bit ^ w_pred;
    assign w_shift_rx = {r_lfsr[PRBS_LEN-2:0], i_bit};
    assign w_werr_sum = r_win_err + NB_WERR'(w_err);

    always_comb begin
        w_next_state   = r_state;
        w_next_lfsr    = r_lfsr;
        w_next_fill    = r_fill;
        w_next_win_cnt = r_win_cnt;
        w_next_win_err = r_win_err;
        if (i_bit_valid) begin
            case (r_state)
                ST_SEARCH: begin
                    w_next_lfsr = w_shift_rx;
                    if (r_fill == NB_FILL'(PRBS_LEN - 1)) begin
                        // an all-zero register is the LFSR lock-up state, never lock on it
                        w_next_fill = '0;
                        if (|w_shift_rx) begin
                            w_next_state   = ST_CHECK;
                            w_next_win_cnt = '0;
                            w_next_win_err = '0;
                        end
                    end else begin
                        w_next_fill = r_fill + NB_FILL'(1);
                    end
                end
                ST_CHECK: begin
                    // free-run on the prediction so a received error cannot corrupt the reference
                    w_next_lfsr = {r_lfsr[PRBS_LEN-2:0], w_pred};
                    if (w_werr_sum >= NB_WERR'(ERR_THR)) begin
                        w_next_state   = ST_SEARCH;
                        w_next_fill    = '0;
                        w_next_win_cnt = '0;
                        w_next_win_err = '0;
                    end else if (r_win_cnt == NB_WIN'(WIN_LEN - 1)) begin
                        w_next_win_cnt = '0;
                        w_next_win_err = '0;
                    end else begin
                        w_next_win_cnt = r_win_cnt + NB_WIN'(1);
                        w_next_win_err = w_werr_sum;
                    end
                end
                default: w_next_state = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            r_state   <= ST_SEARCH;
            r_lfsr    <= '0;
            r_fill    <= '0;
            r_win_cnt <= '0;
            r_win_err <= '0;
        end else begin
            r_state   <= w_next_state;
            r_lfsr    <= w_next_lfsr;
            r_fill    <= w_next_fill;
            r_win_cnt <= w_next_win_cnt;
            r_win_err <= w_next_win_err;
        end
    end

    assign o_lock  = (r_state == ST_CHECK);
    assign o_check = i_bit_valid && (r_state == ST_CHECK);
    assign o_err   = o_check && w_err;

endmodule

// File: rtl/rx_prbs_checker.sv
// rtl/rx_prbs_checker.sv - decimate, slice and PRBS9-check a sample stream; RX_BER_SAT_EN saturates counters
module rx_prbs_checker
    import rx_pkg::*;
#(
    parameter int NB_DATA  = 8,
    parameter int OS       = 8,
    parameter int NB_PHASE = 3,
    parameter int NB_ERR   = 16,
    parameter int NB_BITS  = 32,
    parameter int WIN_LEN  = 64,
    parameter int ERR_THR  = 8
) (
    input  logic                      clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic                      i_valid,
    input  logic signed [NB_DATA-1:0] i_sample,
    input  logic [NB_PHASE-1:0]       i_phase,
    input  logic                      i_clear,
    output logic                      o_bit,
    output logic                      o_bit_valid,
    output logic                      o_lock,
    output logic [NB_ERR-1:0]         o_err_count,
    output logic [NB_BITS-1:0]        o_bit_count
);

    logic [NB_PHASE-1:0] r_sample_cnt;
    logic                w_accept;
    logic                w_decide;
    logic                w_bit;
    logic                w_lock;
    logic                w_check;
    logic                w_err;

    assign w_accept = i_valid && i_enable;
    assign w_decide = w_accept && (r_sample_cnt == i_phase);
    assign w_bit    = ($signed(i_sample) < $signed({NB_DATA{1'b0}})) ? BPSK_NEG_BIT : !BPSK_NEG_BIT;

    rx_prbs_sync #(
        .WIN_LEN (WIN_LEN),
        .ERR_THR (ERR_THR)
    ) u_sync (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_bit_valid (w_decide),
        .i_bit       (w_bit),
        .o_lock      (w_lock),
        .o_check     (w_check),
        .o_err       (w_err)
    );

    assign o_lock = w_lock;

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            r_sample_cnt <= '0;
            o_bit        <= 1'b0;
            o_bit_valid  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_sample_cnt == NB_PHASE'(OS - 1)) begin
                    r_sample_cnt <= '0;
                end else begin
                    r_sample_cnt <= r_sample_cnt + NB_PHASE'(1);
                end
            end
            o_bit_valid <= w_decide;
            if (w_decide) begin
                o_bit <= w_bit;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset || i_clear) begin
            o_err_count <= '0;
            o_bit_count <= '0;
        end else if (w_check) begin
`ifdef RX_BER_SAT_EN
            if (!(&o_bit_count)) begin
                o_bit_count <= o_bit_count + NB_BITS'(1);
            end
            if (w_err && !(&o_err_count)) begin
                o_err_count <= o_err_count + NB_ERR'(1);
            end
`else
            o_bit_count <= o_bit_count + NB_BITS'(1);
            if (w_err) begin
                o_err_count <= o_err_count + NB_ERR'(1);
            end
`endif
        end
    end

endmodule
